// File: rtl/commit_ctrl_if.sv
// rtl/commit_ctrl_if.sv - ROB head, register file write port, LSB store handshake and flush signals
// master: the commit sequencer; slave: the ROB/regfile/LSB side.
interface commit_ctrl_if #(
  parameter int ROB_ADDR_W = 4,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
);
  logic                  head_valid;
  logic                  head_done;
  logic [ROB_ADDR_W-1:0] head_rob_num;
  logic [REG_ADDR_W-1:0] head_dest;
  logic [DATA_W-1:0]     head_data;
  logic                  head_is_store;
  logic                  head_mispredict;
  logic [DATA_W-1:0]     head_target_pc;
  logic                  head_pop;
  logic                  has_from_rob;
  logic [REG_ADDR_W-1:0] dest_reg_num;
  logic [DATA_W-1:0]     in_reg_data;
  logic [ROB_ADDR_W-1:0] in_reg_rob_num;
  logic                  store_req;
  logic                  store_ack;
  logic                  has_misbranch;
  logic [DATA_W-1:0]     jump_pc;

  modport master (
    input  head_valid, head_done, head_rob_num, head_dest, head_data,
           head_is_store, head_mispredict, head_target_pc, store_ack,
    output head_pop, has_from_rob, dest_reg_num, in_reg_data, in_reg_rob_num,
           store_req, has_misbranch, jump_pc
  );

  modport slave (
    output head_valid, head_done, head_rob_num, head_dest, head_data,
           head_is_store, head_mispredict, head_target_pc, store_ack,
    input  head_pop, has_from_rob, dest_reg_num, in_reg_data, in_reg_rob_num,
           store_req, has_misbranch, jump_pc
  );
endinterface

// File: rtl/commit_ctrl.sv
// rtl/commit_ctrl.sv - in-order retirement sequencer between ROB head and register file
// Retires one entry per cycle, serialises stores through the LSB and raises the flush pulse on mispredict.
module commit_ctrl #(
  parameter int ROB_ADDR_W = 4,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  commit_ctrl_if.master bus,
  output logic [31:0]   commit_cnt
);

  typedef enum logic [1:0] {RUN, WAIT_STORE, FLUSH} state_t;

  state_t                state, state_nxt;
  logic                  retire;
  logic                  pop;
  logic                  from_q;
  logic                  mis_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0]     data_q;
  logic [ROB_ADDR_W-1:0] tag_q;
  logic [DATA_W-1:0]     jpc_q;
  logic [31:0]           cnt_q;

  // rst gates the combinational pop so nothing dequeues while the block is held in reset
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    pop       = 1'b0;
    if (rst && rdy) begin
      case (state)
        RUN: begin
          if (bus.head_valid && bus.head_done) begin
            if (bus.head_is_store) begin
              state_nxt = WAIT_STORE;
            end else begin
              retire = 1'b1;
              pop    = 1'b1;
              if (bus.head_mispredict) state_nxt = FLUSH;
            end
          end
        end
        WAIT_STORE: begin
          if (bus.store_ack) begin
            pop       = 1'b1;
            state_nxt = RUN;
          end
        end
        FLUSH:   state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= RUN;
      from_q <= 1'b0;
      mis_q  <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
      tag_q  <= '0;
      jpc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      from_q <= retire;
      mis_q  <= retire && bus.head_mispredict;
      if (retire) begin
        dest_q <= bus.head_dest;
        data_q <= bus.head_data;
        tag_q  <= bus.head_rob_num;
      end
      if (retire && bus.head_mispredict) jpc_q <= bus.head_target_pc;
      if (pop) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.head_pop       = pop;
  assign bus.has_from_rob   = from_q;
  assign bus.dest_reg_num   = dest_q;
  assign bus.in_reg_data    = data_q;
  assign bus.in_reg_rob_num = tag_q;
  assign bus.store_req      = (state == WAIT_STORE);
  assign bus.has_misbranch  = mis_q;
  assign bus.jump_pc        = jpc_q;
  assign commit_cnt         = cnt_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// tb/tb_commit_ctrl.sv - self-checking bench for commit_ctrl
// Directed scenarios followed by randomized traffic against a transaction-level reference model.
module tb_commit_ctrl;
  localparam int RW = 4;
  localparam int GW = 5;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] commit_cnt;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt = 32'd0;

  commit_ctrl_if #(.ROB_ADDR_W(RW), .REG_ADDR_W(GW), .DATA_W(DW)) bus ();

  commit_ctrl #(.ROB_ADDR_W(RW), .REG_ADDR_W(GW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_head(input logic v, input logic d, input logic [RW-1:0] rob,
                          input logic [GW-1:0] dst, input logic [DW-1:0] dat,
                          input logic st, input logic mp, input logic [DW-1:0] tpc);
    bus.head_valid      = v;
    bus.head_done       = d;
    bus.head_rob_num    = rob;
    bus.head_dest       = dst;
    bus.head_data       = dat;
    bus.head_is_store   = st;
    bus.head_mispredict = mp;
    bus.head_target_pc  = tpc;
  endtask

  task automatic idle();
    set_head(1'b0, 1'b0, 4'd0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    bus.store_ack = 1'b0;
  endtask

  function automatic logic [GW-1:0] alu_dst(input int k);
    return (k == 0) ? 5'd5 : (k == 1) ? 5'd6 : 5'd0;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    rdy = 1'b1;
    bus.store_ack = 1'b0;
    set_head(1'b1, 1'b1, 4'd2, 5'd3, 32'h5, 1'b0, 1'b1, 32'h40);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.head_pop, bus.has_from_rob, bus.store_req, bus.has_misbranch} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_pulses got pop/wr/sreq/mis=%b want 0000",
               {bus.head_pop, bus.has_from_rob, bus.store_req, bus.has_misbranch});
    end
    n_cmp++;
    if (bus.dest_reg_num !== 5'd0 || bus.in_reg_data !== 32'h0 || bus.in_reg_rob_num !== 4'd0 ||
        bus.jump_pc !== 32'h0 || commit_cnt !== 32'h0) begin
      n_err++;
      $display("FAIL reset_regs got dest=%h data=%h tag=%h jpc=%h cnt=%h want all 0",
               bus.dest_reg_num, bus.in_reg_data, bus.in_reg_rob_num, bus.jump_pc, commit_cnt);
    end
    idle();
    rst = 1'b1;
    exp_cnt = 32'd0;
  endtask

  task automatic test_alu_burst();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_cmp++;
        if (bus.has_from_rob !== 1'b1 || bus.dest_reg_num !== alu_dst(k-1) ||
            bus.in_reg_data !== 32'h11 * k || bus.in_reg_rob_num !== RW'(k)) begin
          n_err++;
          $display("FAIL alu_write%0d got wr=%b dest=%0d data=%h tag=%0d want wr=1 dest=%0d data=%h tag=%0d",
                   k, bus.has_from_rob, bus.dest_reg_num, bus.in_reg_data, bus.in_reg_rob_num,
                   alu_dst(k-1), 32'h11 * k, k);
        end
      end
      if (k < 3) set_head(1'b1, 1'b1, RW'(k+1), alu_dst(k), 32'h11 * (k+1), 1'b0, 1'b0, 32'h0);
      else idle();
      #1;
      n_cmp++;
      if (bus.head_pop !== (k < 3)) begin
        n_err++;
        $display("FAIL alu_pop%0d got %b want %b", k, bus.head_pop, (k < 3));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.has_from_rob !== 1'b0 || commit_cnt !== 32'd3) begin
      n_err++;
      $display("FAIL alu_end got wr=%b cnt=%0d want wr=0 cnt=3", bus.has_from_rob, commit_cnt);
    end
    exp_cnt = 32'd3;
  endtask

  task automatic test_store();
    @(negedge clk);
    set_head(1'b1, 1'b1, 4'd4, 5'd9, 32'hdead, 1'b1, 1'b0, 32'h0);
    bus.store_ack = 1'b0;
    #1;
    n_cmp++;
    if (bus.head_pop !== 1'b0) begin
      n_err++;
      $display("FAIL store_nopop got %b want 0", bus.head_pop);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.store_req !== 1'b1 || bus.has_from_rob !== 1'b0) begin
        n_err++;
        $display("FAIL store_req%0d got sreq=%b wr=%b want sreq=1 wr=0", i, bus.store_req, bus.has_from_rob);
      end
      bus.store_ack = (i == 3);
      #1;
      n_cmp++;
      if (bus.head_pop !== (i == 3)) begin
        n_err++;
        $display("FAIL store_pop%0d got %b want %b", i, bus.head_pop, (i == 3));
      end
    end
    @(negedge clk);
    idle();
    n_cmp++;
    if (bus.store_req !== 1'b0 || bus.has_from_rob !== 1'b0 || commit_cnt !== exp_cnt + 32'd1) begin
      n_err++;
      $display("FAIL store_done got sreq=%b wr=%b cnt=%0d want sreq=0 wr=0 cnt=%0d",
               bus.store_req, bus.has_from_rob, commit_cnt, exp_cnt + 32'd1);
    end
    exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic test_mispredict();
    @(negedge clk);
    set_head(1'b1, 1'b1, 4'd7, 5'd1, 32'h1004, 1'b0, 1'b1, 32'h2000);
    #1;
    n_cmp++;
    if (bus.head_pop !== 1'b1) begin
      n_err++;
      $display("FAIL jal_pop got %b want 1", bus.head_pop);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.has_from_rob !== 1'b1 || bus.dest_reg_num !== 5'd1 || bus.in_reg_data !== 32'h1004 ||
        bus.in_reg_rob_num !== 4'd7) begin
      n_err++;
      $display("FAIL jal_link got wr=%b dest=%0d data=%h tag=%0d want wr=1 dest=1 data=1004 tag=7",
               bus.has_from_rob, bus.dest_reg_num, bus.in_reg_data, bus.in_reg_rob_num);
    end
    n_cmp++;
    if (bus.has_misbranch !== 1'b1 || bus.jump_pc !== 32'h2000) begin
      n_err++;
      $display("FAIL jal_flush got mis=%b jpc=%h want mis=1 jpc=2000", bus.has_misbranch, bus.jump_pc);
    end
    set_head(1'b1, 1'b1, 4'd8, 5'd3, 32'h55, 1'b0, 1'b0, 32'h0);
    #1;
    n_cmp++;
    if (bus.head_pop !== 1'b0) begin
      n_err++;
      $display("FAIL flush_nopop got %b want 0", bus.head_pop);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.has_from_rob !== 1'b0 || bus.has_misbranch !== 1'b0) begin
      n_err++;
      $display("FAIL flush_quiet got wr=%b mis=%b want 0 0", bus.has_from_rob, bus.has_misbranch);
    end
    #1;
    n_cmp++;
    if (bus.head_pop !== 1'b1) begin
      n_err++;
      $display("FAIL after_flush_pop got %b want 1", bus.head_pop);
    end
    @(negedge clk);
    idle();
    exp_cnt = exp_cnt + 32'd2;
    n_cmp++;
    if (bus.has_from_rob !== 1'b1 || bus.in_reg_rob_num !== 4'd8 || bus.in_reg_data !== 32'h55 ||
        bus.has_misbranch !== 1'b0 || commit_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL after_flush_write got wr=%b tag=%0d data=%h mis=%b cnt=%0d want 1 8 55 0 %0d",
               bus.has_from_rob, bus.in_reg_rob_num, bus.in_reg_data, bus.has_misbranch, commit_cnt, exp_cnt);
    end
  endtask

  task automatic test_rdy_stall();
    @(negedge clk);
    rdy = 1'b0;
    set_head(1'b1, 1'b1, 4'd9, 5'd4, 32'h99, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clk);
        n_cmp++;
        if (bus.has_from_rob !== 1'b0) begin
          n_err++;
          $display("FAIL stall_wr%0d got %b want 0", i, bus.has_from_rob);
        end
      end
      if (i == 2) rdy = 1'b1;
      #1;
      n_cmp++;
      if (bus.head_pop !== (i == 2)) begin
        n_err++;
        $display("FAIL stall_pop%0d got %b want %b", i, bus.head_pop, (i == 2));
      end
    end
    @(negedge clk);
    exp_cnt = exp_cnt + 32'd1;
    n_cmp++;
    if (bus.has_from_rob !== 1'b1 || bus.in_reg_rob_num !== 4'd9 || commit_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL stall_resume got wr=%b tag=%0d cnt=%0d want 1 9 %0d",
               bus.has_from_rob, bus.in_reg_rob_num, commit_cnt, exp_cnt);
    end
    set_head(1'b1, 1'b1, 4'd10, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    rdy = 1'b0;
    bus.store_ack = 1'b1;
    #1;
    n_cmp++;
    if (bus.store_req !== 1'b1 || bus.head_pop !== 1'b0) begin
      n_err++;
      $display("FAIL ack_ignored got sreq=%b pop=%b want 1 0", bus.store_req, bus.head_pop);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.store_req !== 1'b1 || commit_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL ack_held got sreq=%b cnt=%0d want 1 %0d", bus.store_req, commit_cnt, exp_cnt);
    end
    rdy = 1'b1;
    #1;
    n_cmp++;
    if (bus.head_pop !== 1'b1) begin
      n_err++;
      $display("FAIL ack_taken got pop=%b want 1", bus.head_pop);
    end
    @(negedge clk);
    idle();
    exp_cnt = exp_cnt + 32'd1;
    n_cmp++;
    if (bus.store_req !== 1'b0 || commit_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL ack_done got sreq=%b cnt=%0d want 0 %0d", bus.store_req, commit_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_store();
    @(negedge clk);
    set_head(1'b1, 1'b1, 4'd11, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (bus.store_req !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_enter got sreq=%b want 1", bus.store_req);
    end
    rst = 1'b0;
    bus.store_ack = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.head_pop, bus.has_from_rob, bus.store_req, bus.has_misbranch} !== 4'b0000 ||
        bus.dest_reg_num !== 5'd0 || bus.in_reg_data !== 32'h0 || bus.in_reg_rob_num !== 4'd0 ||
        bus.jump_pc !== 32'h0 || commit_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL midrst_clear got pop/wr/sreq/mis=%b dest=%h data=%h tag=%h jpc=%h cnt=%h want all 0",
               {bus.head_pop, bus.has_from_rob, bus.store_req, bus.has_misbranch},
               bus.dest_reg_num, bus.in_reg_data, bus.in_reg_rob_num, bus.jump_pc, commit_cnt);
    end
    idle();
    rst = 1'b1;
    exp_cnt = 32'd0;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    dut.cnt_q = 32'hFFFF_FFFF;
    set_head(1'b1, 1'b1, 4'd12, 5'd2, 32'h7, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (commit_cnt !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_zero got %h want 00000000", commit_cnt);
    end
    set_head(1'b1, 1'b1, 4'd13, 5'd2, 32'h8, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    idle();
    n_cmp++;
    if (commit_cnt !== 32'h1) begin
      n_err++;
      $display("FAIL wrap_one got %h want 00000001", commit_cnt);
    end
  endtask

  // Reference: a head retires when ready in normal flow; stores wait for an accepted ack;
  // a mispredict retire is followed by one dead cycle.
  task automatic test_random();
    bit              waiting_store, in_flush, ret, e_pop;
    bit              e_wr, e_mis;
    logic [GW-1:0]   e_dst;
    logic [DW-1:0]   e_dat, e_jpc;
    logic [RW-1:0]   e_tag;
    logic [31:0]     e_cnt;
    bit              v, d, st, mp, ack, r;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    waiting_store = 0; in_flush = 0;
    e_wr = 0; e_mis = 0; e_dst = '0; e_dat = '0; e_tag = '0; e_jpc = '0; e_cnt = '0;
    for (int c = 0; c < 500; c++) begin
      if (c > 0) @(negedge clk);
      n_cmp++;
      if (bus.has_from_rob !== e_wr || bus.has_misbranch !== e_mis || bus.store_req !== waiting_store) begin
        n_err++;
        $display("FAIL rnd_pulse c=%0d got wr/mis/sreq=%b%b%b want %b%b%b", c,
                 bus.has_from_rob, bus.has_misbranch, bus.store_req, e_wr, e_mis, waiting_store);
      end
      n_cmp++;
      if (bus.dest_reg_num !== e_dst || bus.in_reg_data !== e_dat || bus.in_reg_rob_num !== e_tag ||
          bus.jump_pc !== e_jpc || commit_cnt !== e_cnt) begin
        n_err++;
        $display("FAIL rnd_regs c=%0d got %h %h %h %h %h want %h %h %h %h %h", c,
                 bus.dest_reg_num, bus.in_reg_data, bus.in_reg_rob_num, bus.jump_pc, commit_cnt,
                 e_dst, e_dat, e_tag, e_jpc, e_cnt);
      end
      v = ($urandom_range(3) != 0);
      d = ($urandom_range(3) != 0);
      r = ($urandom_range(4) != 0);
      st = ($urandom_range(3) == 0);
      mp = !st && ($urandom_range(5) == 0);
      ack = ($urandom_range(2) == 0);
      rdy = r;
      bus.store_ack = ack;
      set_head(v, d, RW'($urandom), GW'($urandom), $urandom, st, mp, $urandom);
      #1;
      ret = r && !waiting_store && !in_flush && v && d && !st;
      e_pop = ret || (r && waiting_store && ack);
      n_cmp++;
      if (bus.head_pop !== e_pop) begin
        n_err++;
        $display("FAIL rnd_pop c=%0d got %b want %b", c, bus.head_pop, e_pop);
      end
      e_wr = ret;
      e_mis = ret && mp;
      if (ret) begin
        e_dst = bus.head_dest;
        e_dat = bus.head_data;
        e_tag = bus.head_rob_num;
      end
      if (e_mis) e_jpc = bus.head_target_pc;
      if (e_pop) e_cnt = e_cnt + 32'd1;
      if (r) begin
        if (in_flush) in_flush = 0;
        else if (waiting_store) waiting_store = !ack;
        else if (v && d) begin
          waiting_store = st;
          in_flush = !st && mp;
        end
      end
    end
    @(negedge clk);
    idle();
    rdy = 1'b1;
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_burst();
    test_store();
    test_mispredict();
    test_rdy_stall();
    test_reset_mid_store();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
